// File: rtl/clock_set_ctrl_if.sv
// Set/edit bus between the front-panel controller (master) and the time/date core + display (slave).
// Carries live time/date back to the controller and set flags, hold, load strobes and edit values out.
interface clock_set_ctrl_if;
   logic [4:0]  hour_in;
   logic [5:0]  min_in;
   logic [5:0]  sec_in;
   logic [5:0]  day_in;
   logic [3:0]  month_in;
   logic [11:0] year_in;

   logic        mode_date;
   logic        set_sec;
   logic        set_min;
   logic        set_hour;
   logic        set_day;
   logic        set_month;
   logic        set_year;
   logic        hold;
   logic        ld_time;
   logic        ld_date;
   logic [4:0]  hour_out;
   logic [5:0]  min_out;
   logic [5:0]  sec_out;
   logic [5:0]  day_out;
   logic [3:0]  month_out;
   logic [11:0] year_out;

   modport master (
      input  hour_in, min_in, sec_in, day_in, month_in, year_in,
      output mode_date, set_sec, set_min, set_hour, set_day, set_month, set_year,
      output hold, ld_time, ld_date,
      output hour_out, min_out, sec_out, day_out, month_out, year_out
   );

   modport slave (
      output hour_in, min_in, sec_in, day_in, month_in, year_in,
      input  mode_date, set_sec, set_min, set_hour, set_day, set_month, set_year,
      input  hold, ld_time, ld_date,
      input  hour_out, min_out, sec_out, day_out, month_out, year_out
   );
endinterface

// File: rtl/clock_set_ctrl.sv
// Front-panel controller: key debounce, field-select FSM, snapshot editing with load strobes.
// Optional AUTO_REPEAT_EN: held inc/dec keys repeat after REP_DELAY, then every REP_PERIOD cycles.
module clock_set_ctrl #(
   parameter int DEB_CYCLES = 1000000,
   parameter int REP_DELAY  = 25000000,
   parameter int REP_PERIOD = 5000000,
   parameter int YEAR_MIN   = 0,
   parameter int YEAR_MAX   = 2999
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_mode_n,
   input  logic key_sel_n,
   input  logic key_inc_n,
   input  logic key_dec_n,
   clock_set_ctrl_if.master bus
);

   localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [11:0] Y_MIN = 12'(YEAR_MIN);
   localparam logic [11:0] Y_MAX = 12'(YEAR_MAX);

   generate
      if (YEAR_MAX > 4095 || YEAR_MIN > YEAR_MAX || DEB_CYCLES < 1 ||
          REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_params
         $error("clock_set_ctrl: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE, S_SEC, S_MIN, S_HOUR, S_DAY, S_MONTH, S_YEAR
   } state_t;

   // Key order: 0 mode, 1 sel, 2 inc, 3 dec.
   logic [3:0] key_raw_n;
   logic [3:0] key_press;
   logic [1:0] incdec_lvl;
   assign key_raw_n = {key_dec_n, key_inc_n, key_sel_n, key_mode_n};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_deb
         logic [1:0]     sync_reg;
         logic           lvl_reg;
         logic [DCW-1:0] cnt_reg;
         logic           press_reg;

         // A press is only the accepted released->pressed transition.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_reg  <= 2'b11;
               lvl_reg   <= 1'b1;
               cnt_reg   <= '0;
               press_reg <= 1'b0;
            end else begin
               sync_reg  <= {sync_reg[0], key_raw_n[gi]};
               press_reg <= 1'b0;
               if (sync_reg[1] == lvl_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DCW'(DEB_CYCLES - 1)) begin
                  cnt_reg   <= '0;
                  lvl_reg   <= sync_reg[1];
                  press_reg <= lvl_reg;
               end else begin
                  cnt_reg <= cnt_reg + DCW'(1);
               end
            end
         end

         assign key_press[gi] = press_reg;
         if (gi >= 2) begin : g_lvl
            assign incdec_lvl[gi-2] = lvl_reg;
         end
      end
   endgenerate

   state_t      state_reg, state_next;
   logic        mode_reg, mode_next;
   logic        ld_time_reg, ld_time_next;
   logic        ld_date_reg, ld_date_next;
   logic [4:0]  hour_reg, hour_next;
   logic [5:0]  min_reg, min_next;
   logic [5:0]  sec_reg, sec_next;
   logic [5:0]  day_reg, day_next;
   logic [3:0]  month_reg, month_next;
   logic [11:0] year_reg, year_next;
   logic        inc_ev, dec_ev, step_up, step_dn;

`ifdef AUTO_REPEAT_EN
   localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int RCW     = $clog2(REP_MAX + 1);

   logic [1:0]     rep_key_reg;
   logic           rep_fast_reg;
   logic [RCW-1:0] rep_cnt_reg;
   logic           rep_held, rep_due;

   assign rep_held = (rep_key_reg & ~incdec_lvl) != 2'b00;
   assign rep_due  = rep_fast_reg ? (rep_cnt_reg == RCW'(REP_PERIOD))
                                  : (rep_cnt_reg == RCW'(REP_DELAY));
   assign inc_ev   = key_press[2] | (rep_held & rep_due & rep_key_reg[0]);
   assign dec_ev   = key_press[3] | (rep_held & rep_due & rep_key_reg[1]);

   // Repeat tracks the key pressed alone in an edit state; any state change cancels it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_key_reg  <= 2'b00;
         rep_fast_reg <= 1'b0;
         rep_cnt_reg  <= '0;
      end else if (state_reg != IDLE && !key_press[1] && (key_press[2] ^ key_press[3])) begin
         rep_key_reg  <= key_press[3:2];
         rep_fast_reg <= 1'b0;
         rep_cnt_reg  <= RCW'(1);
      end else if (state_next != state_reg || !rep_held) begin
         rep_key_reg  <= 2'b00;
         rep_fast_reg <= 1'b0;
         rep_cnt_reg  <= '0;
      end else if (rep_due) begin
         rep_fast_reg <= 1'b1;
         rep_cnt_reg  <= RCW'(1);
      end else begin
         rep_cnt_reg <= rep_cnt_reg + RCW'(1);
      end
   end
`else
   logic unused_lvl;
   assign unused_lvl = ^incdec_lvl;
   assign inc_ev     = key_press[2];
   assign dec_ev     = key_press[3];
`endif

   assign step_up = inc_ev & ~dec_ev;
   assign step_dn = dec_ev & ~inc_ev;

   function automatic logic is_leap(input logic [11:0] y);
      return (y[1:0] == 2'b00) && (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
   endfunction

   function automatic logic [5:0] max_day(input logic [3:0] m, input logic [11:0] y);
      case (m)
         4'd2:                      return is_leap(y) ? 6'd29 : 6'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   return 6'd30;
         default:                   return 6'd31;
      endcase
   endfunction

   always_comb begin
      state_next   = state_reg;
      mode_next    = mode_reg;
      ld_time_next = 1'b0;
      ld_date_next = 1'b0;
      hour_next    = hour_reg;
      min_next     = min_reg;
      sec_next     = sec_reg;
      day_next     = day_reg;
      month_next   = month_reg;
      year_next    = year_reg;

      if (state_reg == IDLE) begin
         if (key_press[1]) begin
            state_next = mode_reg ? S_DAY : S_SEC;
            hour_next  = bus.hour_in;
            min_next   = bus.min_in;
            sec_next   = bus.sec_in;
            day_next   = bus.day_in;
            month_next = bus.month_in;
            year_next  = bus.year_in;
         end else if (key_press[0]) begin
            mode_next = ~mode_reg;
         end
      end else if (key_press[1]) begin
         case (state_reg)
            S_SEC:   state_next = S_MIN;
            S_MIN:   state_next = S_HOUR;
            S_DAY:   state_next = S_MONTH;
            S_MONTH: state_next = S_YEAR;
            default: state_next = IDLE;
         endcase
      end else if (step_up || step_dn) begin
         case (state_reg)
            S_SEC: begin
               sec_next = step_up ? ((sec_reg >= 6'd59) ? 6'd0 : sec_reg + 6'd1)
                                  : ((sec_reg == 6'd0) ? 6'd59 : sec_reg - 6'd1);
               ld_time_next = 1'b1;
            end
            S_MIN: begin
               min_next = step_up ? ((min_reg >= 6'd59) ? 6'd0 : min_reg + 6'd1)
                                  : ((min_reg == 6'd0) ? 6'd59 : min_reg - 6'd1);
               ld_time_next = 1'b1;
            end
            S_HOUR: begin
               hour_next = step_up ? ((hour_reg >= 5'd23) ? 5'd0 : hour_reg + 5'd1)
                                   : ((hour_reg == 5'd0) ? 5'd23 : hour_reg - 5'd1);
               ld_time_next = 1'b1;
            end
            S_DAY: begin
               day_next = step_up ? ((day_reg >= max_day(month_reg, year_reg)) ? 6'd1 : day_reg + 6'd1)
                                  : ((day_reg <= 6'd1) ? max_day(month_reg, year_reg) : day_reg - 6'd1);
               ld_date_next = 1'b1;
            end
            S_MONTH: begin
               month_next = step_up ? ((month_reg >= 4'd12) ? 4'd1 : month_reg + 4'd1)
                                    : ((month_reg <= 4'd1) ? 4'd12 : month_reg - 4'd1);
               if (day_reg > max_day(month_next, year_reg))
                  day_next = max_day(month_next, year_reg);
               ld_date_next = 1'b1;
            end
            default: begin
               year_next = step_up ? ((year_reg >= Y_MAX) ? Y_MIN : year_reg + 12'd1)
                                   : ((year_reg <= Y_MIN) ? Y_MAX : year_reg - 12'd1);
               if (day_reg > max_day(month_reg, year_next))
                  day_next = max_day(month_reg, year_next);
               ld_date_next = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         mode_reg    <= 1'b0;
         ld_time_reg <= 1'b0;
         ld_date_reg <= 1'b0;
         hour_reg    <= 5'd0;
         min_reg     <= 6'd0;
         sec_reg     <= 6'd0;
         day_reg     <= 6'd1;
         month_reg   <= 4'd1;
         year_reg    <= Y_MIN;
      end else begin
         state_reg   <= state_next;
         mode_reg    <= mode_next;
         ld_time_reg <= ld_time_next;
         ld_date_reg <= ld_date_next;
         hour_reg    <= hour_next;
         min_reg     <= min_next;
         sec_reg     <= sec_next;
         day_reg     <= day_next;
         month_reg   <= month_next;
         year_reg    <= year_next;
      end
   end

   assign bus.mode_date = mode_reg;
   assign bus.set_sec   = (state_reg == S_SEC);
   assign bus.set_min   = (state_reg == S_MIN);
   assign bus.set_hour  = (state_reg == S_HOUR);
   assign bus.set_day   = (state_reg == S_DAY);
   assign bus.set_month = (state_reg == S_MONTH);
   assign bus.set_year  = (state_reg == S_YEAR);
   assign bus.hold      = (state_reg != IDLE);
   assign bus.ld_time   = ld_time_reg;
   assign bus.ld_date   = ld_date_reg;
   assign bus.hour_out  = hour_reg;
   assign bus.min_out   = min_reg;
   assign bus.sec_out   = sec_reg;
   assign bus.day_out   = day_reg;
   assign bus.month_out = month_reg;
   assign bus.year_out  = year_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: table of key presses with expected flags, strobes and edit values.
// Hand-written sequences cover reset, a short key glitch and reset during an edit.
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] keys_n = 4'hF;

   clock_set_ctrl_if bus();

   clock_set_ctrl #(.DEB_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_mode_n (keys_n[0]),
      .key_sel_n  (keys_n[1]),
      .key_inc_n  (keys_n[2]),
      .key_dec_n  (keys_n[3]),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   localparam logic [3:0] KM = 4'd1, KS = 4'd2, KI = 4'd4, KD = 4'd8;
   localparam logic [5:0] ST_I = 6'd0, ST_SEC = 6'd1, ST_MIN = 6'd2, ST_HR = 6'd4,
                          ST_DAY = 6'd8, ST_MON = 6'd16, ST_YR = 6'd32;
   localparam logic [1:0] LT = 2'b01, LD = 2'b10, L0 = 2'b00;

   typedef struct {
      logic [3:0]  keys;
      int          live;
      logic        md;
      logic [5:0]  set;
      logic [1:0]  ld;
      logic [38:0] ed;
   } vec_t;

   vec_t vt[$];
   int   n_pass = 0;
   int   n_total = 0;

   logic [7:0]  flag_w;
   logic [38:0] edit_w;
   assign flag_w = {bus.mode_date, bus.set_year, bus.set_month, bus.set_day,
                    bus.set_hour, bus.set_min, bus.set_sec, bus.hold};
   assign edit_w = {bus.hour_out, bus.min_out, bus.sec_out, bus.day_out, bus.month_out, bus.year_out};

   int lh [5] = '{10, 23, 23, 23, 23};
   int lm [5] = '{20, 59, 59, 59, 59};
   int ls [5] = '{30, 59, 59, 59, 59};
   int ld_ [5] = '{31, 31, 31, 31, 31};
   int lmo[5] = '{1, 1, 1, 1, 12};
   int ly [5] = '{2023, 2023, 2000, 1900, 2999};

   function automatic logic [38:0] ed(int h, int m, int s, int d, int mo, int y);
      return {5'(h), 6'(m), 6'(s), 6'(d), 4'(mo), 12'(y)};
   endfunction

   function automatic vec_t mk(logic [3:0] k, int l, logic md, logic [5:0] s, logic [1:0] ldx, logic [38:0] e);
      vec_t r;
      r.keys = k; r.live = l; r.md = md; r.set = s; r.ld = ldx; r.ed = e;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic set_live(input int i);
      bus.hour_in  = 5'(lh[i]);
      bus.min_in   = 6'(lm[i]);
      bus.sec_in   = 6'(ls[i]);
      bus.day_in   = 6'(ld_[i]);
      bus.month_in = 4'(lmo[i]);
      bus.year_in  = 12'(ly[i]);
   endtask

   // Holds the keys low for low_cycles, releases, and counts strobe cycles throughout.
   task automatic press(input logic [3:0] mask, input int low_cycles, output int nt, output int nd);
      nt = 0;
      nd = 0;
      @(negedge clk);
      keys_n = ~mask;
      repeat (low_cycles) begin
         @(negedge clk);
         nt += int'(bus.ld_time);
         nd += int'(bus.ld_date);
      end
      keys_n = 4'hF;
      repeat (12) begin
         @(negedge clk);
         nt += int'(bus.ld_time);
         nd += int'(bus.ld_date);
      end
   endtask

   initial begin
      int nt, nd;
      set_live(0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_flags", 64'(flag_w), 64'd0);
      check("reset_edit", 64'(edit_w), 64'(ed(0, 0, 0, 1, 1, 0)));
      check("reset_ld", {62'd0, bus.ld_date, bus.ld_time}, 64'd0);
      rst_n = 1'b1;

      vt.push_back(mk(KS,      0, 0, ST_SEC, L0, ed(10, 20, 30, 31, 1, 2023)));
      vt.push_back(mk(KI,      0, 0, ST_SEC, LT, ed(10, 20, 31, 31, 1, 2023)));
      vt.push_back(mk(KS,      0, 0, ST_MIN, L0, ed(10, 20, 31, 31, 1, 2023)));
      vt.push_back(mk(KD,      0, 0, ST_MIN, LT, ed(10, 19, 31, 31, 1, 2023)));
      vt.push_back(mk(KS,      0, 0, ST_HR,  L0, ed(10, 19, 31, 31, 1, 2023)));
      vt.push_back(mk(KI,      0, 0, ST_HR,  LT, ed(11, 19, 31, 31, 1, 2023)));
      vt.push_back(mk(KS,      0, 0, ST_I,   L0, ed(11, 19, 31, 31, 1, 2023)));
      vt.push_back(mk(KS,      1, 0, ST_SEC, L0, ed(23, 59, 59, 31, 1, 2023)));
      vt.push_back(mk(KI,      1, 0, ST_SEC, LT, ed(23, 59, 0, 31, 1, 2023)));
      vt.push_back(mk(KD,      1, 0, ST_SEC, LT, ed(23, 59, 59, 31, 1, 2023)));
      vt.push_back(mk(KI | KD, 1, 0, ST_SEC, L0, ed(23, 59, 59, 31, 1, 2023)));
      vt.push_back(mk(KS | KI, 1, 0, ST_MIN, L0, ed(23, 59, 59, 31, 1, 2023)));
      vt.push_back(mk(KI,      1, 0, ST_MIN, LT, ed(23, 0, 59, 31, 1, 2023)));
      vt.push_back(mk(KS,      1, 0, ST_HR,  L0, ed(23, 0, 59, 31, 1, 2023)));
      vt.push_back(mk(KI,      1, 0, ST_HR,  LT, ed(0, 0, 59, 31, 1, 2023)));
      vt.push_back(mk(KD,      1, 0, ST_HR,  LT, ed(23, 0, 59, 31, 1, 2023)));
      vt.push_back(mk(KS,      1, 0, ST_I,   L0, ed(23, 0, 59, 31, 1, 2023)));
      vt.push_back(mk(KI,      1, 0, ST_I,   L0, ed(23, 0, 59, 31, 1, 2023)));
      vt.push_back(mk(KM,      1, 1, ST_I,   L0, ed(23, 0, 59, 31, 1, 2023)));
      vt.push_back(mk(KM | KS, 1, 1, ST_DAY, L0, ed(23, 59, 59, 31, 1, 2023)));
      vt.push_back(mk(KI,      1, 1, ST_DAY, LD, ed(23, 59, 59, 1, 1, 2023)));
      vt.push_back(mk(KD,      1, 1, ST_DAY, LD, ed(23, 59, 59, 31, 1, 2023)));
      vt.push_back(mk(KS,      1, 1, ST_MON, L0, ed(23, 59, 59, 31, 1, 2023)));
      vt.push_back(mk(KM,      1, 1, ST_MON, L0, ed(23, 59, 59, 31, 1, 2023)));
      vt.push_back(mk(KI,      1, 1, ST_MON, LD, ed(23, 59, 59, 28, 2, 2023)));
      vt.push_back(mk(KS,      1, 1, ST_YR,  L0, ed(23, 59, 59, 28, 2, 2023)));
      vt.push_back(mk(KI,      1, 1, ST_YR,  LD, ed(23, 59, 59, 28, 2, 2024)));
      vt.push_back(mk(KS,      1, 1, ST_I,   L0, ed(23, 59, 59, 28, 2, 2024)));
      vt.push_back(mk(KS,      2, 1, ST_DAY, L0, ed(23, 59, 59, 31, 1, 2000)));
      vt.push_back(mk(KS,      2, 1, ST_MON, L0, ed(23, 59, 59, 31, 1, 2000)));
      vt.push_back(mk(KI,      2, 1, ST_MON, LD, ed(23, 59, 59, 29, 2, 2000)));
      vt.push_back(mk(KS,      2, 1, ST_YR,  L0, ed(23, 59, 59, 29, 2, 2000)));
      vt.push_back(mk(KD,      2, 1, ST_YR,  LD, ed(23, 59, 59, 28, 2, 1999)));
      vt.push_back(mk(KS,      2, 1, ST_I,   L0, ed(23, 59, 59, 28, 2, 1999)));
      vt.push_back(mk(KS,      3, 1, ST_DAY, L0, ed(23, 59, 59, 31, 1, 1900)));
      vt.push_back(mk(KS,      3, 1, ST_MON, L0, ed(23, 59, 59, 31, 1, 1900)));
      vt.push_back(mk(KI,      3, 1, ST_MON, LD, ed(23, 59, 59, 28, 2, 1900)));
      vt.push_back(mk(KS,      3, 1, ST_YR,  L0, ed(23, 59, 59, 28, 2, 1900)));
      vt.push_back(mk(KS,      3, 1, ST_I,   L0, ed(23, 59, 59, 28, 2, 1900)));
      vt.push_back(mk(KS,      4, 1, ST_DAY, L0, ed(23, 59, 59, 31, 12, 2999)));
      vt.push_back(mk(KS,      4, 1, ST_MON, L0, ed(23, 59, 59, 31, 12, 2999)));
      vt.push_back(mk(KI,      4, 1, ST_MON, LD, ed(23, 59, 59, 31, 1, 2999)));
      vt.push_back(mk(KD,      4, 1, ST_MON, LD, ed(23, 59, 59, 31, 12, 2999)));
      vt.push_back(mk(KS,      4, 1, ST_YR,  L0, ed(23, 59, 59, 31, 12, 2999)));
      vt.push_back(mk(KI,      4, 1, ST_YR,  LD, ed(23, 59, 59, 31, 12, 0)));
      vt.push_back(mk(KD,      4, 1, ST_YR,  LD, ed(23, 59, 59, 31, 12, 2999)));
      vt.push_back(mk(KS,      4, 1, ST_I,   L0, ed(23, 59, 59, 31, 12, 2999)));
      vt.push_back(mk(KM,      4, 0, ST_I,   L0, ed(23, 59, 59, 31, 12, 2999)));

      foreach (vt[i]) begin
         set_live(vt[i].live);
         press(vt[i].keys, 12, nt, nd);
         check($sformatf("v%0d_flags", i), 64'(flag_w), 64'({vt[i].md, vt[i].set, |vt[i].set}));
         check($sformatf("v%0d_ld", i), {32'(nt), 32'(nd)}, {32'(vt[i].ld[0]), 32'(vt[i].ld[1])});
         check($sformatf("v%0d_edit", i), 64'(edit_w), 64'(vt[i].ed));
         $display("vec %0d keys=%b flags=%b ld_time_cycles=%0d ld_date_cycles=%0d edit=%0h",
                  i, vt[i].keys, flag_w, nt, nd, edit_w);
      end

      // Sel glitch shorter than the debounce window must be ignored.
      press(KS, 2, nt, nd);
      check("glitch_flags", 64'(flag_w), 64'd0);
      check("glitch_ld", {32'(nt), 32'(nd)}, 64'd0);
      $display("glitch flags=%b ld_cycles=%0d/%0d", flag_w, nt, nd);

      // Enter S_HOUR, then reset mid-edit.
      press(KS, 12, nt, nd);
      press(KS, 12, nt, nd);
      press(KS, 12, nt, nd);
      check("hour_flags", 64'(flag_w), 64'({1'b0, ST_HR, 1'b1}));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_flags", 64'(flag_w), 64'd0);
      check("midreset_edit", 64'(edit_w), 64'(ed(0, 0, 0, 1, 1, 0)));
      nt = 0;
      nd = 0;
      repeat (4) begin
         @(negedge clk);
         nt += int'(bus.ld_time);
         nd += int'(bus.ld_date);
      end
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         nt += int'(bus.ld_time);
         nd += int'(bus.ld_date);
      end
      check("midreset_ld", {32'(nt), 32'(nd)}, 64'd0);
      check("postreset_flags", 64'(flag_w), 64'd0);
      $display("midreset flags=%b edit=%0h ld_cycles=%0d/%0d", flag_w, edit_w, nt, nd);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
